// File: rtl/cordic_angle.sv
// Phase-accumulator DDS driving a 16-stage pipelined rotation-mode CORDIC.
// Emits one quadrature sample (A*2^16*cos, A*2^16*sin) per clock, 17 edges after capture.
module cordic_angle #(
  parameter int ITER = 16,
  parameter int PHW  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        A,
  input  logic [PHW-1:0]     W,
  output logic signed [32:0] x_out,
  output logic signed [32:0] y_out
);

  localparam int XW = 35;  // x/y datapath width
  localparam int ZW = 26;  // angle datapath width
  localparam int ZF = 24;  // angle fraction bits: one turn = 2^ZF
  localparam int OW = 33;  // output width

  localparam logic [31:0]           GAIN_COMP = 32'd39797;  // round(2^16 / 1.646760258)
  localparam logic [PHW-1:0]        HALF_TURN = {1'b1, {(PHW-1){1'b0}}};
  localparam logic signed [XW-1:0]  SAT_HI    = 35'sh0_FFFF_FFFF;
  localparam logic signed [XW-1:0]  SAT_LO    = -35'sh1_0000_0000;

  // round(atan(2^-k) / (2*pi) * 2^24)
  function automatic logic signed [ZW-1:0] atan_k(input int k);
    case (k)
      0:       return 26'sd2097152;
      1:       return 26'sd1238021;
      2:       return 26'sd654136;
      3:       return 26'sd332050;
      4:       return 26'sd166669;
      5:       return 26'sd83416;
      6:       return 26'sd41718;
      7:       return 26'sd20860;
      8:       return 26'sd10430;
      9:       return 26'sd5215;
      10:      return 26'sd2608;
      11:      return 26'sd1304;
      12:      return 26'sd652;
      13:      return 26'sd326;
      14:      return 26'sd163;
      15:      return 26'sd81;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [OW-1:0] saturate(input logic signed [XW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[OW-1:0];
    else if (v < SAT_LO) return SAT_LO[OW-1:0];
    else                 return v[OW-1:0];
  endfunction

  logic [PHW-1:0]        phase;
  logic signed [XW-1:0]  x_s [0:ITER];
  logic signed [XW-1:0]  y_s [0:ITER];
  logic signed [ZW-1:0]  z_s [0:ITER];
  logic [ITER:0]         neg_s;

  logic                  fold;
  logic [PHW-1:0]        resid;
  logic [31:0]           amp_prod;
  logic signed [XW-1:0]  x_in;
  logic signed [ZW-1:0]  z_in;
  logic signed [XW-1:0]  x_fin;
  logic signed [XW-1:0]  y_fin;

  // Quadrants 2 and 3 are rotated by half a turn so the residual stays in
  // [-90, +90) degrees, inside the CORDIC convergence range; the output is
  // negated at the end to undo the fold.
  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    fold     = phase[PHW-1] ^ phase[PHW-2];
    resid    = fold ? (phase - HALF_TURN) : phase;
    z_in     = {{(ZW-ZF){resid[PHW-1]}}, resid, {(ZF-PHW){1'b0}}};
    amp_prod = A * GAIN_COMP;
    x_in     = {{(XW-32){1'b0}}, amp_prod};
    x_fin    = neg_s[ITER] ? -x_s[ITER] : x_s[ITER];
    y_fin    = neg_s[ITER] ? -y_s[ITER] : y_s[ITER];
  end

  // NOTE: the pipeline arrays are plain flops, not RAM, so resetting them is
  // cheap and guarantees zero outputs until the first real sample arrives.
  // NOTE: all state updates are non-blocking so every stage reads the values
  // its predecessor held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      neg_s <= '0;
      x_out <= '0;
      y_out <= '0;
      for (int i = 0; i <= ITER; i++) begin
        x_s[i] <= '0;
        y_s[i] <= '0;
        z_s[i] <= '0;
      end
    end else begin
      phase  <= phase + W;
      x_s[0] <= x_in;
      y_s[0] <= '0;
      z_s[0] <= z_in;
      neg_s  <= {neg_s[ITER-1:0], fold};
      for (int i = 1; i <= ITER; i++) begin
        if (!z_s[i-1][ZW-1]) begin
          x_s[i] <= x_s[i-1] - (y_s[i-1] >>> (i-1));
          y_s[i] <= y_s[i-1] + (x_s[i-1] >>> (i-1));
          z_s[i] <= z_s[i-1] - atan_k(i-1);
        end else begin
          x_s[i] <= x_s[i-1] + (y_s[i-1] >>> (i-1));
          y_s[i] <= y_s[i-1] - (x_s[i-1] >>> (i-1));
          z_s[i] <= z_s[i-1] + atan_k(i-1);
        end
      end
      x_out <= saturate(x_fin);
      y_out <= saturate(y_fin);
    end
  end

endmodule

// File: tb/tb_cordic_angle.sv
// Self-checking bench for cordic_angle: an ideal phase-accumulator/cosine model
// predicts every output sample; each scenario task compares inline.
module tb_cordic_angle;

  localparam real TWO_PI = 6.283185307179586;
  localparam int  LAT    = 18;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [15:0]        A = '0;
  logic [15:0]        W = '0;
  logic signed [32:0] x_out;
  logic signed [32:0] y_out;

  int tests = 0;
  int fails = 0;

  cordic_angle #(.ITER(16), .PHW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .W     (W),
    .x_out (x_out),
    .y_out (y_out)
  );

  always #5 clk = ~clk;

  // Reference: phase and amplitude seen at each edge since reset release.
  int unsigned m_phase;
  int unsigned ph_hist[$];
  int unsigned a_hist[$];
  int          cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      cyc     <= 0;
      ph_hist.delete();
      a_hist.delete();
    end else begin
      ph_hist.push_back(m_phase);
      a_hist.push_back(A);
      m_phase <= (m_phase + W) % 65536;
      cyc     <= cyc + 1;
    end
  end

  function automatic real abs_r(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real xr();
    return real'(longint'(x_out));
  endfunction

  function automatic real yr();
    return real'(longint'(y_out));
  endfunction

  // Expected outputs after `cyc` edges: zero until the first sample emerges,
  // then the ideal scaled cosine/sine of the sample captured LAT edges earlier.
  function automatic void expect_now(output real ex, output real ey, output real tol);
    real th;
    real amp;
    if (cyc < LAT) begin
      ex = 0.0; ey = 0.0; tol = 0.0;
    end else begin
      th  = TWO_PI * real'(ph_hist[cyc-LAT]) / 65536.0;
      amp = real'(a_hist[cyc-LAT]) * 65536.0;
      ex  = amp * $cos(th);
      ey  = amp * $sin(th);
      tol = 4.0 * real'(a_hist[cyc-LAT]) + 32.0;
    end
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    A = 16'd1024;
    W = 16'd1024;
    rst_n = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      tests++;
      if (x_out !== 33'sd0 || y_out !== 33'sd0) begin
        fails++;
        $display("FAIL reset_hold x=%0d y=%0d want 0/0", x_out, y_out);
      end
    end
  endtask

  task automatic test_basic();
    real ex, ey, tol;
    A = 16'd1024;
    W = 16'd1024;
    do_reset();
    repeat (130) begin
      @(posedge clk); #1;
      expect_now(ex, ey, tol);
      tests++;
      if (abs_r(xr() - ex) > tol || abs_r(yr() - ey) > tol) begin
        fails++;
        $display("FAIL basic cyc=%0d x=%0d y=%0d want %0.0f/%0.0f tol %0.0f", cyc, x_out, y_out, ex, ey, tol);
      end
      if (cyc == 18 || cyc == 34 || cyc == 50) begin
        ex = (cyc == 18) ? 67108864.0 : (cyc == 50) ? -67108864.0 : 0.0;
        ey = (cyc == 34) ? 67108864.0 : 0.0;
        tests++;
        if (abs_r(xr() - ex) > 4128.0 || abs_r(yr() - ey) > 4128.0) begin
          fails++;
          $display("FAIL basic_quarter cyc=%0d x=%0d y=%0d want %0.0f/%0.0f", cyc, x_out, y_out, ex, ey);
        end
      end
    end
  endtask

  task automatic test_on_the_fly();
    real ex, ey, tol;
    A = 16'd2048;
    W = 16'd2048;
    repeat (100) begin
      @(posedge clk); #1;
      expect_now(ex, ey, tol);
      tests++;
      if (abs_r(xr() - ex) > tol || abs_r(yr() - ey) > tol) begin
        fails++;
        $display("FAIL on_the_fly cyc=%0d x=%0d y=%0d want %0.0f/%0.0f tol %0.0f", cyc, x_out, y_out, ex, ey, tol);
      end
    end
  endtask

  task automatic test_quadrant();
    real ex, ey, tol;
    int found = 0;
    A = 16'd2048;
    W = 16'd4096;
    do_reset();
    repeat (60) begin
      @(posedge clk); #1;
      expect_now(ex, ey, tol);
      tests++;
      if (abs_r(xr() - ex) > tol || abs_r(yr() - ey) > tol) begin
        fails++;
        $display("FAIL quadrant cyc=%0d x=%0d y=%0d want %0.0f/%0.0f tol %0.0f", cyc, x_out, y_out, ex, ey, tol);
      end
      if (cyc >= LAT && ph_hist[cyc-LAT] == 32'h6000) begin
        found++;
        tests++;
        if (abs_r(xr() + 94906266.0) > 8224.0 || abs_r(yr() - 94906266.0) > 8224.0) begin
          fails++;
          $display("FAIL quadrant_135 x=%0d y=%0d want -94906266/94906266", x_out, y_out);
        end
      end
    end
    tests++;
    if (found == 0) begin
      fails++;
      $display("FAIL quadrant_135_seen count=%0d want >0", found);
    end
  endtask

  task automatic test_slow();
    real ex, ey, tol, r2;
    real target = 67108864.0 * 67108864.0;
    A = 16'd1024;
    W = 16'd182;
    do_reset();
    repeat (LAT + 1000) begin
      @(posedge clk); #1;
      expect_now(ex, ey, tol);
      tests++;
      if (abs_r(xr() - ex) > tol || abs_r(yr() - ey) > tol) begin
        fails++;
        $display("FAIL slow cyc=%0d x=%0d y=%0d want %0.0f/%0.0f tol %0.0f", cyc, x_out, y_out, ex, ey, tol);
      end
      if (cyc >= LAT) begin
        r2 = xr() * xr() + yr() * yr();
        tests++;
        if (abs_r(r2 - target) > 1.0e-3 * target) begin
          fails++;
          $display("FAIL slow_magnitude cyc=%0d r2=%e want %e", cyc, r2, target);
        end
      end
    end
  endtask

  task automatic test_full_scale();
    real ex, ey, tol;
    A = 16'd65535;
    W = 16'h4000;
    do_reset();
    repeat (40) begin
      @(posedge clk); #1;
      expect_now(ex, ey, tol);
      tests++;
      if (abs_r(xr() - ex) > tol || abs_r(yr() - ey) > tol) begin
        fails++;
        $display("FAIL full_scale cyc=%0d x=%0d y=%0d want %0.0f/%0.0f tol %0.0f", cyc, x_out, y_out, ex, ey, tol);
      end
    end
  endtask

  task automatic test_zero_amp();
    A = 16'd0;
    W = 16'd777;
    repeat (LAT) @(posedge clk);
    repeat (12) begin
      @(posedge clk); #1;
      tests++;
      if (x_out !== 33'sd0 || y_out !== 33'sd0) begin
        fails++;
        $display("FAIL zero_amp x=%0d y=%0d want 0/0", x_out, y_out);
      end
    end
  endtask

  task automatic test_hold();
    real ex, ey, tol;
    A = 16'd3000;
    W = 16'd0;
    repeat (40) begin
      @(posedge clk); #1;
      expect_now(ex, ey, tol);
      tests++;
      if (abs_r(xr() - ex) > tol || abs_r(yr() - ey) > tol) begin
        fails++;
        $display("FAIL hold cyc=%0d x=%0d y=%0d want %0.0f/%0.0f tol %0.0f", cyc, x_out, y_out, ex, ey, tol);
      end
    end
  endtask

  task automatic test_random();
    real ex, ey, tol;
    repeat (1500) begin
      @(posedge clk); #1;
      expect_now(ex, ey, tol);
      tests++;
      if (abs_r(xr() - ex) > tol || abs_r(yr() - ey) > tol) begin
        fails++;
        $display("FAIL random cyc=%0d x=%0d y=%0d want %0.0f/%0.0f tol %0.0f", cyc, x_out, y_out, ex, ey, tol);
      end
      if ($urandom_range(0, 15) == 0) begin
        A = 16'($urandom_range(0, 65535));
        W = 16'($urandom_range(0, 65535));
      end
    end
  endtask

  task automatic test_async_reset();
    real ex, ey, tol;
    A = 16'd1024;
    W = 16'd1000;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (x_out !== 33'sd0 || y_out !== 33'sd0) begin
      fails++;
      $display("FAIL async_reset_immediate x=%0d y=%0d want 0/0", x_out, y_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      expect_now(ex, ey, tol);
      tests++;
      if (abs_r(xr() - ex) > tol || abs_r(yr() - ey) > tol) begin
        fails++;
        $display("FAIL async_restart cyc=%0d x=%0d y=%0d want %0.0f/%0.0f tol %0.0f", cyc, x_out, y_out, ex, ey, tol);
      end
      if (cyc == LAT) begin
        tests++;
        if (abs_r(xr() - 67108864.0) > 4128.0 || abs_r(yr()) > 4128.0) begin
          fails++;
          $display("FAIL async_first_sample x=%0d y=%0d want 67108864/0", x_out, y_out);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_on_the_fly();
    test_quadrant();
    test_slow();
    test_full_scale();
    test_zero_amp();
    test_hold();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
